// File: rtl/serial_pkg.sv
// Shared definitions for serial_fifo_ctrl: register map, bit indices, sequencer states.
// Optional loopback (IE bit7) is compiled in only when SERIAL_LOOPBACK_EN is defined.
package serial_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_IE     = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int unsigned STAT_RX_NONEMPTY = 0;
  localparam int unsigned STAT_TX_NOTFULL  = 1;
  localparam int unsigned STAT_RX_OVF      = 2;
  localparam int unsigned STAT_TX_EMPTY    = 3;
  localparam int unsigned STAT_SEQ_IDLE    = 4;

  localparam int unsigned IE_RX       = 0;
  localparam int unsigned IE_TX_EMPTY = 1;
  localparam int unsigned IE_LOOPBACK = 7;

  localparam int unsigned HOLD_CYCLES = 2;
  localparam int unsigned HoldCntW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset. A pop on an empty FIFO is ignored;
// a push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic [WIDTH-1:0]      head_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  push_eff, pop_eff;

  // count never exceeds Depth, so its MSB alone marks full
  assign full_o   = count_q[DEPTH_LOG2];
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign head_o   = mem_q[rd_ptr_q];
  assign pop_eff  = pop_i & ~empty_o;
  assign push_eff = push_i & (~full_o | pop_eff);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/serial_fifo_ctrl.sv
// FIFO-buffered serial controller: RX/TX FIFOs, status/IE registers, transmit sequencer.
// Define SERIAL_LOOPBACK_EN to add the IE bit7 loopback path (TX head pushed into RX).
module serial_fifo_ctrl
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned RX_DEPTH_LOG2 = 4,
  parameter int unsigned TX_DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  readEnable_i,
  input  logic [1:0]            addr_i,
  input  logic [31:0]           dataSave_i,
  output logic [31:0]           dataLoad_o,
  output logic                  int_o,
  input  logic                  rxdReady_i,
  input  logic [DATA_WIDTH-1:0] rxdData_i,
  input  logic                  txdBusy_i,
  output logic                  txdStart_o,
  output logic [DATA_WIDTH-1:0] txdData_o
);

  logic                  enable_q;
  logic                  access, rd_access, wr_access;
  logic                  ovf_q, ovf_set, ovf_clr;
  logic [1:0]            ie_q;
  logic                  loopback;
  seq_state_e            state_q;
  logic [HoldCntW-1:0]   hold_cnt_q;
  logic                  txd_start_q, int_q;
  logic [DATA_WIDTH-1:0] txd_data_q;

  logic                    rx_push, rx_pop, rx_full, rx_empty;
  logic [RX_DEPTH_LOG2:0]  rx_count;
  logic [DATA_WIDTH-1:0]   rx_wdata, rx_head;
  logic                    tx_push, tx_pop, tx_full, tx_empty;
  logic [TX_DEPTH_LOG2:0]  tx_count;
  logic [DATA_WIDTH-1:0]   tx_head;

  logic unused_wdata;
  assign unused_wdata = ^dataSave_i;

  // A held strobe must act once, so only its rising edge counts as an access
  assign access    = enable_i & ~enable_q;
  assign rd_access = access & readEnable_i;
  assign wr_access = access & ~readEnable_i;
  assign rx_pop    = rd_access & (addr_i == REG_DATA);
  assign tx_push   = wr_access & (addr_i == REG_DATA);
  assign tx_pop    = (state_q == StStart);

`ifdef SERIAL_LOOPBACK_EN
  logic lb_q;
  assign loopback = lb_q;
  assign rx_push  = lb_q ? tx_pop : rxdReady_i;
  assign rx_wdata = lb_q ? tx_head : rxdData_i;
`else
  assign loopback = 1'b0;
  assign rx_push  = rxdReady_i;
  assign rx_wdata = rxdData_i;
`endif

  assign ovf_set = rx_push & rx_full & ~rx_pop;
  assign ovf_clr = wr_access & (addr_i == REG_STATUS) & dataSave_i[STAT_RX_OVF];

  sync_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_LOG2 (RX_DEPTH_LOG2)
  ) u_rx_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (rx_push),
    .wdata_i (rx_wdata),
    .pop_i   (rx_pop),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count),
    .head_o  (rx_head)
  );

  sync_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (tx_push),
    .wdata_i (dataSave_i[DATA_WIDTH-1:0]),
    .pop_i   (tx_pop),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count),
    .head_o  (tx_head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable_q <= 1'b0;
      ovf_q    <= 1'b0;
      ie_q     <= '0;
`ifdef SERIAL_LOOPBACK_EN
      lb_q     <= 1'b0;
`endif
    end else begin
      enable_q <= enable_i;
      // A drop in the same cycle as a clear wins, so no overflow goes unreported
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      if (wr_access && (addr_i == REG_IE)) begin
        ie_q <= {dataSave_i[IE_TX_EMPTY], dataSave_i[IE_RX]};
`ifdef SERIAL_LOOPBACK_EN
        lb_q <= dataSave_i[IE_LOOPBACK];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_cnt_q  <= '0;
      txd_start_q <= 1'b0;
      txd_data_q  <= '0;
      int_q       <= 1'b0;
    end else begin
      txd_start_q <= 1'b0;
      int_q       <= (ie_q[0] & ~rx_empty) | (ie_q[1] & tx_empty & (state_q == StIdle));
      unique case (state_q)
        StIdle: begin
          if (!tx_empty && !txdBusy_i) state_q <= StStart;
        end
        StStart: begin
          if (loopback) begin
            state_q <= StIdle;
          end else begin
            txd_start_q <= 1'b1;
            txd_data_q  <= tx_head;
            hold_cnt_q  <= '0;
            state_q     <= StHold;
          end
        end
        // Transmitter raises busy with some latency; ignore it until HOLD expires
        StHold: begin
          if (hold_cnt_q == HoldCntW'(HOLD_CYCLES - 1)) state_q <= StDrain;
          else hold_cnt_q <= hold_cnt_q + 1'b1;
        end
        StDrain: begin
          if (!txdBusy_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign txdStart_o = txd_start_q;
  assign txdData_o  = txd_data_q;
  assign int_o      = int_q;

  always_comb begin
    dataLoad_o = '0;
    unique case (addr_i)
      REG_DATA: begin
        if (!rx_empty) dataLoad_o[DATA_WIDTH-1:0] = rx_head;
      end
      REG_STATUS: begin
        dataLoad_o[STAT_RX_NONEMPTY] = ~rx_empty;
        dataLoad_o[STAT_TX_NOTFULL]  = ~tx_full;
        dataLoad_o[STAT_RX_OVF]      = ovf_q;
        dataLoad_o[STAT_TX_EMPTY]    = tx_empty;
        dataLoad_o[STAT_SEQ_IDLE]    = (state_q == StIdle);
      end
      REG_IE: begin
        dataLoad_o[IE_RX]       = ie_q[0];
        dataLoad_o[IE_TX_EMPTY] = ie_q[1];
`ifdef SERIAL_LOOPBACK_EN
        dataLoad_o[IE_LOOPBACK] = lb_q;
`endif
      end
      REG_COUNT: begin
        dataLoad_o[8 +: TX_DEPTH_LOG2 + 1] = tx_count;
        dataLoad_o[0 +: RX_DEPTH_LOG2 + 1] = rx_count;
      end
      default: ;
    endcase
  end

endmodule
